cordic_phase_gen: RTL
=====================

Name: cordic_phase_gen

Overview:
- Synthesisable AXI-Stream phase-word source for the CORDIC sin/cos cores. It replaces the behavioural phase sweep used in simulation.
- Generates a radian phase ramp in Q3.13 format, wrapped into [PI_NEG, PI_POS].
- The increment and beat count are programmable, and the block honours tready backpressure.
- Sits in front of each cordic_0 instance in the signal-synthesis path that feeds the FIR filter.

Parameters:
- COUNT_W, 16, width of the beat-count input.
- DEFAULT_INC, 200, increment loaded at reset (Q3.13; about 2 MHz at a 500 MHz CORDIC clock).
- START_PHASE, 0, first phase word emitted after every start.

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset
- start_i  in  1  one-cycle pulse; begins a sweep when IDLE
- stop_i  in  1  one-cycle pulse; ends the sweep after the held beat completes
- phase_inc_i  in  16  signed Q3.13 increment
- inc_load_i  in  1  latches phase_inc_i into the increment register
- count_i  in  COUNT_W  beats per sweep; 0 means continuous
- m_axis_phase_tvalid  out  1  phase beat valid
- m_axis_phase_tready  in  1  downstream ready
- m_axis_phase_tdata  out  16  signed Q3.13 phase
- wrap_o  out  1  qualifies tdata: this beat was produced by a -2*PI wrap
- busy_o  out  1  high in RUN and STOP
- done_o  out  1  one-cycle pulse when a sweep ends

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - tvalid=0, tdata=0, wrap_o=0, busy_o=0, done_o=0, state=IDLE.
  - Increment register = DEFAULT_INC; beat counter = 0.
- Handshake:
  - A beat transfers on a cycle where tvalid and tready are both high.
  - Once asserted, tvalid, tdata and wrap_o stay stable until the transfer; no retraction, including on stop_i.
  - Throughput is 1 beat per cycle while tready=1.
- Phase arithmetic:
  - sum = tdata + inc_reg, computed at 17-bit signed width.
  - If sum > PI_POS (25736): next = sum - TWO_PI (51472) and wrap_o=1. Otherwise next = sum and wrap_o=0.
  - A value exactly equal to PI_POS is legal and does not wrap.
  - Output is always in [-25736, +25736].
- Increment register:
  - inc_load_i writes phase_inc_i saturated to the range [0, PI_POS]. Negative values load 0; values above PI_POS load 25736.
  - A load may occur in any state and takes effect at the next transfer.
  - If inc_load_i and a transfer occur in the same cycle, that transfer uses the old value.
- IDLE:
  - tvalid=0.
  - start_i → RUN. In that cycle: count_i is sampled, the counter is cleared, and tdata is set to START_PHASE with wrap_o=0.
  - tvalid rises on the cycle after the start_i pulse.
- RUN:
  - On each transfer: tdata←next, counter+1.
  - If count≠0 and the counter reaches count on a transfer: tvalid←0, done_o pulses the next cycle, → IDLE.
  - stop_i → STOP. stop_i in the same cycle as a transfer is treated as STOP with no beat pending: tvalid←0, done_o pulses, → IDLE.
  - start_i is ignored while RUN or STOP.
- STOP:
  - The held beat waits for tready. On its transfer: tvalid←0, done_o pulses, → IDLE.
  - No further beats are generated.
- Simultaneous events:
  - stop_i together with the final counted beat gives exactly one done_o pulse.
  - start_i in the same cycle as the done_o pulse is ignored; a new sweep needs a fresh start_i in IDLE.
- Reset mid-operation: all outputs return to their reset values immediately and asynchronously. The partial sweep is discarded and done_o does not fire.

Decomposition:
- Package cordic_phase_pkg:
  - PI_POS = 16'sh6488, PI_NEG = 16'sh9B78, TWO_PI = 17'sd51472.
  - Phase word typedef (signed 16-bit).
  - State enum {IDLE, RUN, STOP}.
- Sub-module phase_wrap_add: combinational 17-bit add, compare and subtract. Outputs next phase and a wrap flag. It is reused by any future dual-tone generator.

Test Plan:
1. Ramp and wrap: inc=200, count=0, tready=1, start.
   - Beats 0, 200, 400, …; beat 128 = 25600 with wrap_o=0.
   - Beat 129 = -25672 with wrap_o=1.
   - Beat 130 = -25472 with wrap_o=0.
2. Counted sweep: inc_load=3000, count=5, tready=1.
   - Beats 0, 3000, 6000, 9000, 12000.
   - tvalid falls after the 5th transfer; done_o pulses once; busy_o falls.
3. Backpressure: inc=200, tready random at 50% for 200 cycles.
   - tdata and wrap_o hold constant during every stall.
   - The accepted sequence equals the ramp from test 1 with no gaps or duplicates.
4. Stop during stall: tready=0 while tdata=400, then pulse stop_i; hold tready low 10 cycles, then raise it.
   - tvalid stays 1 with tdata=400 throughout the stall.
   - One transfer completes, then tvalid=0 and done_o=1 for one cycle.
5. Boundary and saturation: inc_load with phase_inc_i=16'h7FFF.
   - Register holds 25736; beats are 0, 25736 (wrap_o=0), 0 (wrap_o=1), 25736, …
   - A load of -5 yields a constant stream of 0.
6. Async reset mid-run: assert rst_n low between clock edges during RUN.
   - tvalid and busy_o drop before the next edge; tdata=0; no done_o.
   - After release, a start_i pulse yields 0, 200, … (DEFAULT_INC).

Source files
------------

// File: rtl/cordic_phase_pkg.sv
// Shared constants, types and helpers for the CORDIC phase-word source.
// Phase words are signed Q3.13 radians.
package cordic_phase_pkg;

  localparam logic signed [15:0] PI_POS = 16'sh6488;
  localparam logic signed [15:0] PI_NEG = 16'sh9B78;
  localparam logic signed [16:0] TWO_PI = 17'sd51472;

  typedef logic signed [15:0] phase_t;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  // Clamp a requested increment into [0, PI_POS] so one step never exceeds a half turn.
  function automatic phase_t sat_inc(input phase_t v);
    phase_t r;
    r = v;
    if (v < 0) begin
      r = '0;
    end else if (v > PI_POS) begin
      r = PI_POS;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_wrap_add.sv
// Combinational phase accumulate step: 17-bit add, compare against +PI, wrap by -2*PI.
module phase_wrap_add
  import cordic_phase_pkg::*;
(
  input  logic signed [15:0] i_phase,
  input  logic signed [15:0] i_inc,
  output logic signed [15:0] o_next,
  output logic               o_wrap
);

  logic signed [16:0] w_sum;

  assign w_sum  = {i_phase[15], i_phase} + {i_inc[15], i_inc};
  assign o_wrap = (w_sum > $signed({1'b0, PI_POS}));
  // Subtracting 2*PI modulo 2^16 gives the same low 16 bits as the 17-bit subtraction.
  assign o_next = o_wrap ? (w_sum[15:0] - TWO_PI[15:0]) : w_sum[15:0];

endmodule

// File: rtl/cordic_phase_gen.sv
// AXI-Stream radian phase ramp source for the CORDIC sin/cos cores.
// Programmable increment and beat count, full tready backpressure.
module cordic_phase_gen
  import cordic_phase_pkg::*;
#(
  parameter int unsigned        COUNT_W     = 16,
  parameter logic signed [15:0] DEFAULT_INC = 16'sd200,
  parameter logic signed [15:0] START_PHASE = 16'sd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic signed [15:0]  phase_inc_i,
  input  logic                inc_load_i,
  input  logic [COUNT_W-1:0]  count_i,
  output logic                m_axis_phase_tvalid,
  input  logic                m_axis_phase_tready,
  output logic signed [15:0]  m_axis_phase_tdata,
  output logic                wrap_o,
  output logic                busy_o,
  output logic                done_o
);

  state_e              r_state, w_state_nxt;
  logic                r_tvalid, w_tvalid_nxt;
  logic signed [15:0]  r_tdata, w_tdata_nxt;
  logic                r_wrap, w_wrap_nxt;
  logic                r_done, w_done_nxt;
  logic [COUNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [COUNT_W-1:0]  r_limit, w_limit_nxt;
  logic signed [15:0]  r_inc;

  logic signed [15:0]  w_next_phase;
  logic                w_next_wrap;
  logic                w_xfer;
  logic [COUNT_W-1:0]  w_cnt_inc;
  logic                w_last;

  phase_wrap_add u_wrap_add (
    .i_phase (r_tdata),
    .i_inc   (r_inc),
    .o_next  (w_next_phase),
    .o_wrap  (w_next_wrap)
  );

  assign w_xfer    = r_tvalid & m_axis_phase_tready;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (r_limit != '0) && (w_cnt_inc == r_limit);

  always_comb begin
    w_state_nxt  = r_state;
    w_tvalid_nxt = r_tvalid;
    w_tdata_nxt  = r_tdata;
    w_wrap_nxt   = r_wrap;
    w_done_nxt   = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_limit_nxt  = r_limit;
    unique case (r_state)
      IDLE: begin
        // A start coinciding with the previous sweep's done pulse is dropped.
        if (start_i && !r_done) begin
          w_state_nxt  = RUN;
          w_tvalid_nxt = 1'b1;
          w_tdata_nxt  = START_PHASE;
          w_wrap_nxt   = 1'b0;
          w_cnt_nxt    = '0;
          w_limit_nxt  = count_i;
        end
      end
      RUN: begin
        if (w_xfer) begin
          w_tdata_nxt = w_next_phase;
          w_wrap_nxt  = w_next_wrap;
          w_cnt_nxt   = w_cnt_inc;
          if (stop_i || w_last) begin
            w_tvalid_nxt = 1'b0;
            w_done_nxt   = 1'b1;
            w_state_nxt  = IDLE;
          end
        end else if (stop_i) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_xfer) begin
          w_tvalid_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_limit  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tdata  <= w_tdata_nxt;
      r_wrap   <= w_wrap_nxt;
      r_done   <= w_done_nxt;
      r_cnt    <= w_cnt_nxt;
      r_limit  <= w_limit_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc <= DEFAULT_INC;
    end else if (inc_load_i) begin
      r_inc <= sat_inc(phase_inc_i);
    end
  end

  assign m_axis_phase_tvalid = r_tvalid;
  assign m_axis_phase_tdata  = r_tdata;
  assign wrap_o              = r_wrap;
  assign busy_o              = (r_state != IDLE);
  assign done_o              = r_done;

endmodule
